branch_resolver: RTL and testbench
==================================

# branch_resolver

- Fetch-to-EX companion of the branch target buffer.
- Records each fetched instruction's PC and BTB prediction in an in-flight queue, then pops the matching entry when that instruction resolves in EX.
- Compares prediction against the actual outcome, raises a redirect and pipeline flush on a mispredict, and drives a registered training update back into the predictor.
- Sits between the fetch stage, the EX stage and the predictor's update port.

## Interface

Parameters:
- DEPTH, 4 — in-flight queue entries (power of two, ≥2)
- FLUSH_CYCLES, 2 — cycles `flush` stays high after a mispredict (≥1)

Ports (one clock; reset is asynchronous, active-low):
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset (reset asserted while 0)
- fetchValid  in  1  instruction accepted by fetch this cycle
- fetchPc  in  32  its PC
- fetchHit  in  1  BTB predicted taken
- fetchTarget  in  32  predicted target
- fetchStall  out  1  queue full, fetch must hold
- exValid  in  1  instruction resolves in EX (pops queue head)
- exBranch  in  1  instruction is a jump/branch
- exTaken  in  1  control transfer actually taken
- exTarget  in  32  actual target
- redirectValid  out  1  one-cycle redirect pulse
- redirectPc  out  32  correct next PC
- flush  out  1  squash younger pipeline stages
- bpUpdValid  out  1  predictor update strobe
- bpExBranch, bpExTaken  out  1 each  predictor update fields
- bpExPc, bpExTarget  out  32 each  predictor update fields

## Operation

- Queue: circular buffer of {pc, hit, target}; wr/rd pointers of log2(DEPTH) bits that wrap naturally; count of log2(DEPTH)+1 bits.
- `fetchStall` = (count == DEPTH), combinational.
- Push on `fetchValid && !fetchStall && state==RUN`; a push while full or outside RUN is dropped.
- Pop on `exValid && count!=0 && state==RUN`; `exValid` on an empty queue is ignored (no update, no redirect).
- Push and pop in the same cycle are both allowed when full: the pop frees the slot, count unchanged. `fetchStall` still reflects the pre-pop count.
- Resolution of the popped head (actual next PC = exTaken ? exTarget : pc+4, 32-bit wrap):
  - hit && (!exTaken || exTarget != target) -> mispredict
  - !hit && exTaken -> mispredict
  - otherwise correct.
- Update on every pop: bpUpdValid=1, bpExBranch=exBranch, bpExTaken=exTaken, bpExPc=head pc, bpExTarget=exTarget.
- FSM:
  - RUN: on mispredict -> FLUSH. Queue is cleared (pointers and count to 0), redirectValid=1, redirectPc=actual next PC, counter loads FLUSH_CYCLES-1. A push in the same cycle is discarded.
  - FLUSH: flush=1; pushes/pops ignored; counter decrements; at 0 -> RUN.

## Timing

- All outputs except `fetchStall` are registered: update and redirect appear the cycle after the pop.
- `flush` rises with `redirectValid` and stays high exactly FLUSH_CYCLES cycles.
- bpUpdValid and redirectValid are single-cycle pulses. bpEx* fields hold their last value when bpUpdValid=0.
- Reset (any time, including mid-FLUSH):
  - state=RUN, queue empty, fetchStall=0.
  - redirectValid=0, redirectPc=0, flush=0.
  - bpUpdValid=0, bpExBranch=0, bpExTaken=0, bpExPc=0, bpExTarget=0.
- First push is accepted on the first rising edge after rst deasserts.

## Configuration

- `BRANCH_STATS_EN` defined:
  - Adds outputs statBranches (32) and statMispredicts (32).
  - statBranches increments on each pop with exBranch=1; statMispredicts increments on each mispredict.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

## Test plan

- Push pc=0x100 (hit=1, tgt=0x200), pop with exBranch=1, exTaken=1, exTarget=0x200 -> next cycle bpUpdValid=1, bpExPc=0x100, redirectValid=0, flush=0.
- Push pc=0x100 hit=1 tgt=0x200, pop with exTaken=0 -> redirectValid=1, redirectPc=0x104, flush high 2 cycles, queue empty; a fetchValid during flush is not stored.
- Push pc=0x40 hit=0, pop with exTaken=1, exTarget=0x80 -> redirectPc=0x80. Then pc=0xFFFFFFFC hit=1 tgt=0x10, pop with exTaken=0 -> redirectPc=0x00000000.
- Push 4 entries -> fetchStall=1; push+pop same cycle keeps count=4, the pushed entry is popped 4th later (FIFO order, pointer wrap).
- exValid with empty queue -> no bpUpdValid; rst=0 mid-FLUSH -> flush=0 immediately, all outputs at reset values.
- With BRANCH_STATS_EN: 3 correct branches + 1 mispredict -> statBranches=4, statMispredicts=1.

Source files
------------

// File: rtl/branch_resolver.sv
// Tracks fetched PCs and their BTB predictions until they resolve in EX, then redirects on a mispredict and trains the predictor.
// Optional BRANCH_STATS_EN adds saturating branch/mispredict counters.
module branch_resolver #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetchValid,
  input  logic [31:0] fetchPc,
  input  logic        fetchHit,
  input  logic [31:0] fetchTarget,
  output logic        fetchStall,
  input  logic        exValid,
  input  logic        exBranch,
  input  logic        exTaken,
  input  logic [31:0] exTarget,
  output logic        redirectValid,
  output logic [31:0] redirectPc,
  output logic        flush,
  output logic        bpUpdValid,
  output logic        bpExBranch,
  output logic        bpExTaken,
  output logic [31:0] bpExPc,
  output logic [31:0] bpExTarget
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] statBranches,
  output logic [31:0] statMispredicts
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [FW-1:0]   r_flush_cnt;
  logic            r_flush;

  logic [31:0]     r_q_pc  [DEPTH];
  logic            r_q_hit [DEPTH];
  logic [31:0]     r_q_tgt [DEPTH];
  logic [PW-1:0]   r_wr;
  logic [PW-1:0]   r_rd;
  logic [CW-1:0]   r_count;

  logic            r_redirect_valid;
  logic [31:0]     r_redirect_pc;
  logic            r_upd_valid;
  logic            r_upd_branch;
  logic            r_upd_taken;
  logic [31:0]     r_upd_pc;
  logic [31:0]     r_upd_target;

  logic            w_run;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic [31:0]     w_head_pc;
  logic            w_head_hit;
  logic [31:0]     w_head_tgt;
  logic [31:0]     w_actual_pc;
  logic            w_mispredict;

  assign w_run      = (r_state == ST_RUN);
  assign w_full     = (r_count == CW'(DEPTH));
  assign fetchStall = w_full;

  assign w_pop  = exValid && (r_count != '0) && w_run;
  // A full queue still accepts a push when the head pops in the same cycle.
  assign w_push = fetchValid && w_run && (!w_full || w_pop);

  assign w_head_pc   = r_q_pc[r_rd];
  assign w_head_hit  = r_q_hit[r_rd];
  assign w_head_tgt  = r_q_tgt[r_rd];
  assign w_actual_pc = exTaken ? exTarget : (w_head_pc + 32'd4);

  always_comb begin
    w_mispredict = 1'b0;
    if (w_pop) begin
      if (w_head_hit) w_mispredict = !exTaken || (exTarget != w_head_tgt);
      else            w_mispredict = exTaken;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:   if (w_mispredict) w_state_next = ST_FLUSH;
      ST_FLUSH: if (r_flush_cnt == '0) w_state_next = ST_RUN;
      default:  w_state_next = ST_RUN;
    endcase
  end

  // Queue storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push && !w_mispredict) begin
      r_q_pc[r_wr]  <= fetchPc;
      r_q_hit[r_wr] <= fetchHit;
      r_q_tgt[r_wr] <= fetchTarget;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state          <= ST_RUN;
      r_flush_cnt      <= '0;
      r_flush          <= 1'b0;
      r_wr             <= '0;
      r_rd             <= '0;
      r_count          <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_upd_valid      <= 1'b0;
      r_upd_branch     <= 1'b0;
      r_upd_taken      <= 1'b0;
      r_upd_pc         <= '0;
      r_upd_target     <= '0;
    end else begin
      r_state <= w_state_next;
      r_flush <= (w_state_next == ST_FLUSH);
      if (w_run)                   r_flush_cnt <= FLUSH_LOAD;
      else if (r_flush_cnt != '0)  r_flush_cnt <= r_flush_cnt - FW'(1);

      if (w_mispredict) begin
        r_wr    <= '0;
        r_rd    <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wr <= r_wr + PW'(1);
        if (w_pop)  r_rd <= r_rd + PW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end

      r_upd_valid <= w_pop;
      if (w_pop) begin
        r_upd_branch <= exBranch;
        r_upd_taken  <= exTaken;
        r_upd_pc     <= w_head_pc;
        r_upd_target <= exTarget;
      end

      r_redirect_valid <= w_mispredict;
      if (w_mispredict) r_redirect_pc <= w_actual_pc;
    end
  end

  assign redirectValid = r_redirect_valid;
  assign redirectPc    = r_redirect_pc;
  assign flush         = r_flush;
  assign bpUpdValid    = r_upd_valid;
  assign bpExBranch    = r_upd_branch;
  assign bpExTaken     = r_upd_taken;
  assign bpExPc        = r_upd_pc;
  assign bpExTarget    = r_upd_target;

`ifdef BRANCH_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispredicts;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      if (w_pop && exBranch && (r_stat_branches != '1))
        r_stat_branches <= r_stat_branches + 32'd1;
      if (w_mispredict && (r_stat_mispredicts != '1))
        r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
    end
  end

  assign statBranches    = r_stat_branches;
  assign statMispredicts = r_stat_mispredicts;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_branch_resolver;
  localparam int DEPTH = 4;
  localparam int FC    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetchValid, fetchHit, exValid, exBranch, exTaken;
  logic [31:0] fetchPc, fetchTarget, exTarget;
  logic        fetchStall, redirectValid, flush, bpUpdValid, bpExBranch, bpExTaken;
  logic [31:0] redirectPc, bpExPc, bpExTarget;
`ifdef BRANCH_STATS_EN
  logic [31:0] statBranches, statMispredicts;
`endif

  always #5 clk = ~clk;

  branch_resolver #(.DEPTH(DEPTH), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst),
    .fetchValid(fetchValid), .fetchPc(fetchPc), .fetchHit(fetchHit), .fetchTarget(fetchTarget),
    .fetchStall(fetchStall),
    .exValid(exValid), .exBranch(exBranch), .exTaken(exTaken), .exTarget(exTarget),
    .redirectValid(redirectValid), .redirectPc(redirectPc), .flush(flush),
    .bpUpdValid(bpUpdValid), .bpExBranch(bpExBranch), .bpExTaken(bpExTaken),
    .bpExPc(bpExPc), .bpExTarget(bpExTarget)
`ifdef BRANCH_STATS_EN
    , .statBranches(statBranches), .statMispredicts(statMispredicts)
`endif
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        hit;
    logic [31:0] tgt;
  } ent_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  ent_t q[$];
  int   flush_left;
  logic e_upd, e_br, e_tk, e_rv, e_flush;
  logic [31:0] e_pc, e_tgt, e_rpc;
  longint e_sb, e_sm;

  task automatic model_reset();
    q.delete();
    flush_left = 0;
    e_upd = 0; e_br = 0; e_tk = 0; e_rv = 0; e_flush = 0;
    e_pc = 0; e_tgt = 0; e_rpc = 0;
    e_sb = 0; e_sm = 0;
  endtask

  // Advances the model by one clock using the inputs currently applied.
  task automatic model_step();
    ent_t head;
    logic pop, push, mis;
    logic [31:0] nxt;
    e_upd = 0;
    e_rv  = 0;
    if (flush_left == 0) begin
      pop  = exValid && (q.size() > 0);
      push = fetchValid && ((q.size() < DEPTH) || pop);
      mis  = 0;
      if (pop) begin
        head  = q.pop_front();
        e_upd = 1; e_br = exBranch; e_tk = exTaken; e_pc = head.pc; e_tgt = exTarget;
        nxt   = exTaken ? exTarget : head.pc + 32'd4;
        mis   = head.hit ? (!exTaken || exTarget != head.tgt) : exTaken;
        if (exBranch && e_sb < 64'hFFFFFFFF) e_sb++;
        $display("pop pc=%h taken=%b target=%h mispredict=%b", head.pc, exTaken, exTarget, mis);
        if (mis) begin
          if (e_sm < 64'hFFFFFFFF) e_sm++;
          q.delete();
          e_rv = 1; e_rpc = nxt;
          flush_left = FC;
        end
      end
      if (push && !mis) q.push_back('{pc: fetchPc, hit: fetchHit, tgt: fetchTarget});
    end else begin
      flush_left--;
    end
    e_flush = (flush_left > 0);
  endtask

  task automatic clk_cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    fetchValid = 0; fetchPc = 0; fetchHit = 0; fetchTarget = 0;
    exValid = 0; exBranch = 0; exTaken = 0; exTarget = 0;
  endtask

  task automatic push_one(input logic [31:0] pc, input logic hit, input logic [31:0] tgt);
    set_idle();
    fetchValid = 1; fetchPc = pc; fetchHit = hit; fetchTarget = tgt;
    clk_cycle();
    set_idle();
  endtask

  task automatic pop_one(input logic br, input logic tk, input logic [31:0] tgt);
    set_idle();
    exValid = 1; exBranch = br; exTaken = tk; exTarget = tgt;
    clk_cycle();
    set_idle();
  endtask

  task automatic test_reset();
    set_idle();
    model_reset();
    @(posedge clk);
    #1;
    n_checks++;
    if ({redirectValid, redirectPc, flush, bpUpdValid, bpExBranch, bpExTaken, bpExPc, bpExTarget, fetchStall} !== '0)
      $display("FAIL reset_outputs: got rv=%b rpc=%h fl=%b upd=%b pc=%h tgt=%h stall=%b want all zero",
               redirectValid, redirectPc, flush, bpUpdValid, bpExPc, bpExTarget, fetchStall);
    else n_pass++;
    rst = 1;
  endtask

  task automatic test_correct();
    push_one(32'h100, 1, 32'h200);
    pop_one(1, 1, 32'h200);
    n_checks++;
    if (bpUpdValid !== 1'b1 || bpExPc !== 32'h100 || bpExTarget !== 32'h200 || bpExBranch !== 1'b1 || bpExTaken !== 1'b1)
      $display("FAIL correct_update: got upd=%b pc=%h tgt=%h br=%b tk=%b want 1 00000100 00000200 1 1",
               bpUpdValid, bpExPc, bpExTarget, bpExBranch, bpExTaken);
    else n_pass++;
    n_checks++;
    if (redirectValid !== 1'b0 || flush !== 1'b0)
      $display("FAIL correct_no_redirect: got rv=%b flush=%b want 0 0", redirectValid, flush);
    else n_pass++;
    clk_cycle();
    n_checks++;
    if (bpUpdValid !== 1'b0 || bpExPc !== 32'h100)
      $display("FAIL update_pulse_hold: got upd=%b pc=%h want 0 00000100", bpUpdValid, bpExPc);
    else n_pass++;
  endtask

  task automatic test_mispredict();
    push_one(32'h100, 1, 32'h200);
    pop_one(1, 0, 32'h0);
    n_checks++;
    if (redirectValid !== 1'b1 || redirectPc !== 32'h104 || flush !== 1'b1)
      $display("FAIL mispredict_redirect: got rv=%b rpc=%h flush=%b want 1 00000104 1", redirectValid, redirectPc, flush);
    else n_pass++;
    fetchValid = 1; fetchPc = 32'h300; fetchHit = 0; fetchTarget = 0;
    clk_cycle();
    n_checks++;
    if (redirectValid !== 1'b0 || flush !== 1'b1)
      $display("FAIL flush_cycle2: got rv=%b flush=%b want 0 1", redirectValid, flush);
    else n_pass++;
    fetchValid = 1; fetchPc = 32'h304;
    clk_cycle();
    n_checks++;
    if (flush !== 1'b0)
      $display("FAIL flush_end: got flush=%b want 0", flush);
    else n_pass++;
    set_idle();
    pop_one(1, 1, 32'h999);
    n_checks++;
    if (bpUpdValid !== 1'b0 || redirectValid !== 1'b0)
      $display("FAIL flush_drops_push: got upd=%b rv=%b want 0 0", bpUpdValid, redirectValid);
    else n_pass++;
  endtask

  task automatic test_redirect_wrap();
    push_one(32'h40, 0, 32'h0);
    pop_one(1, 1, 32'h80);
    n_checks++;
    if (redirectValid !== 1'b1 || redirectPc !== 32'h80)
      $display("FAIL redirect_taken: got rv=%b rpc=%h want 1 00000080", redirectValid, redirectPc);
    else n_pass++;
    clk_cycle();
    clk_cycle();
    push_one(32'hFFFFFFFC, 1, 32'h10);
    pop_one(1, 0, 32'h0);
    n_checks++;
    if (redirectValid !== 1'b1 || redirectPc !== 32'h0)
      $display("FAIL redirect_wrap: got rv=%b rpc=%h want 1 00000000", redirectValid, redirectPc);
    else n_pass++;
    clk_cycle();
    clk_cycle();
  endtask

  task automatic test_full_fifo();
    logic [31:0] exp_order [4];
    exp_order[0] = 32'h1004; exp_order[1] = 32'h1008; exp_order[2] = 32'h100C; exp_order[3] = 32'h2000;
    for (int i = 0; i < 4; i++) push_one(32'h1000 + 32'(i * 4), 0, 32'h0);
    n_checks++;
    if (fetchStall !== 1'b1)
      $display("FAIL full_stall: got %b want 1", fetchStall);
    else n_pass++;
    fetchValid = 1; fetchPc = 32'h2000; fetchHit = 0; fetchTarget = 0;
    exValid = 1; exBranch = 0; exTaken = 0; exTarget = 0;
    n_checks++;
    if (fetchStall !== 1'b1)
      $display("FAIL stall_pre_pop: got %b want 1", fetchStall);
    else n_pass++;
    clk_cycle();
    set_idle();
    n_checks++;
    if (bpUpdValid !== 1'b1 || bpExPc !== 32'h1000 || fetchStall !== 1'b1)
      $display("FAIL push_pop_full: got upd=%b pc=%h stall=%b want 1 00001000 1", bpUpdValid, bpExPc, fetchStall);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      pop_one(0, 0, 32'h0);
      n_checks++;
      if (bpUpdValid !== 1'b1 || bpExPc !== exp_order[i])
        $display("FAIL fifo_order_%0d: got upd=%b pc=%h want 1 %h", i, bpUpdValid, bpExPc, exp_order[i]);
      else n_pass++;
    end
    n_checks++;
    if (fetchStall !== 1'b0 || redirectValid !== 1'b0)
      $display("FAIL drained: got stall=%b rv=%b want 0 0", fetchStall, redirectValid);
    else n_pass++;
  endtask

  task automatic test_empty_pop();
    pop_one(1, 1, 32'h44);
    n_checks++;
    if (bpUpdValid !== 1'b0 || redirectValid !== 1'b0 || flush !== 1'b0)
      $display("FAIL empty_pop: got upd=%b rv=%b flush=%b want 0 0 0", bpUpdValid, redirectValid, flush);
    else n_pass++;
  endtask

  task automatic test_reset_mid_flush();
    push_one(32'h500, 1, 32'h600);
    pop_one(1, 1, 32'h700);
    n_checks++;
    if (flush !== 1'b1 || redirectPc !== 32'h700)
      $display("FAIL pre_reset_flush: got flush=%b rpc=%h want 1 00000700", flush, redirectPc);
    else n_pass++;
    #2 rst = 0;
    #1;
    n_checks++;
    if ({redirectValid, redirectPc, flush, bpUpdValid, bpExBranch, bpExTaken, bpExPc, bpExTarget, fetchStall} !== '0)
      $display("FAIL reset_mid_flush: got rv=%b rpc=%h fl=%b upd=%b pc=%h tgt=%h stall=%b want all zero",
               redirectValid, redirectPc, flush, bpUpdValid, bpExPc, bpExTarget, fetchStall);
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 1;
    model_reset();
    push_one(32'h800, 0, 32'h0);
    pop_one(0, 0, 32'h0);
    n_checks++;
    if (bpUpdValid !== 1'b1 || bpExPc !== 32'h800 || flush !== 1'b0)
      $display("FAIL after_reset_push: got upd=%b pc=%h flush=%b want 1 00000800 0", bpUpdValid, bpExPc, flush);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] tgts [4];
    tgts[0] = 32'h100; tgts[1] = 32'h200; tgts[2] = 32'h300; tgts[3] = 32'h400;
    for (int c = 0; c < 400; c++) begin
      fetchValid  = ($urandom_range(0, 9) < 7);
      fetchPc     = $urandom & 32'hFFFC;
      fetchHit    = $urandom_range(0, 1);
      fetchTarget = tgts[$urandom_range(0, 3)];
      exValid     = ($urandom_range(0, 9) < 5);
      exBranch    = $urandom_range(0, 1);
      exTaken     = $urandom_range(0, 1);
      exTarget    = tgts[$urandom_range(0, 3)];
      n_checks++;
      if (fetchStall !== (q.size() == DEPTH))
        $display("FAIL rand_stall c%0d: got %b want %b", c, fetchStall, (q.size() == DEPTH));
      else n_pass++;
      clk_cycle();
      n_checks++;
      if ({bpUpdValid, bpExBranch, bpExTaken, bpExPc, bpExTarget, redirectValid, redirectPc, flush} !==
          {e_upd, e_br, e_tk, e_pc, e_tgt, e_rv, e_rpc, e_flush})
        $display("FAIL rand_outputs c%0d: got upd=%b br=%b tk=%b pc=%h tgt=%h rv=%b rpc=%h fl=%b want %b %b %b %h %h %b %h %b",
                 c, bpUpdValid, bpExBranch, bpExTaken, bpExPc, bpExTarget, redirectValid, redirectPc, flush,
                 e_upd, e_br, e_tk, e_pc, e_tgt, e_rv, e_rpc, e_flush);
      else n_pass++;
    end
    set_idle();
    for (int i = 0; i < FC + 1; i++) clk_cycle();
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    rst = 0;
    #1;
    @(posedge clk);
    #1;
    rst = 1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      push_one(32'h900 + 32'(i * 4), 1, 32'hA00);
      pop_one(1, 1, 32'hA00);
    end
    push_one(32'h910, 1, 32'hA00);
    pop_one(1, 0, 32'h0);
    n_checks++;
    if (statBranches !== 32'd4 || statMispredicts !== 32'd1 || statBranches !== 32'(e_sb) || statMispredicts !== 32'(e_sm))
      $display("FAIL stats: got branches=%0d mispredicts=%0d want 4 1", statBranches, statMispredicts);
    else n_pass++;
    for (int i = 0; i < FC; i++) clk_cycle();
  endtask
`endif

  initial begin
    set_idle();
    test_reset();
    test_correct();
    test_mispredict();
    test_redirect_wrap();
    test_full_fifo();
    test_empty_pop();
    test_reset_mid_flush();
    test_random();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
